// File: rtl/acumulador_pkg.sv
// Shared constants and FSM encoding for the product accumulator.
// Optional saturating arithmetic is selected with the ACUM_SATURATE_EN macro.
package acumulador_pkg;

  localparam int PROD_W        = 8;
  localparam int ACC_W_DEF     = 11;
  localparam int N_SAMPLES_DEF = 8;
  localparam int CNT_W_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/acumulador_productos_sumador_sat.sv
// Combinational accumulator adder returning the wrapped sum and the carry-out.
// With ACUM_SATURATE_EN defined, the sum clamps to all-ones on carry.
module sumador_sat
  import acumulador_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full_sum;

  assign full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign carry_o  = full_sum[ACC_W];

`ifdef ACUM_SATURATE_EN
  // Once clamped, any further nonzero product carries again and re-clamps.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
  assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/acumulador_productos.sv
// Frame accumulator for the multiplier product stream with valid/ready handshakes.
// Build option: ACUM_SATURATE_EN (saturating sum inside sumador_sat).
module acumulador_productos
  import acumulador_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_SAMPLES);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_xfer;
  logic             out_xfer;

  sumador_sat #(
    .ACC_W (ACC_W)
  ) u_sumador (
    .acc_i   (acc_q),
    .prod_i  (product),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // rst_n is folded in so in_ready reads low for the whole reset window.
  assign in_ready = rst_n & ena & (state_q != DONE) & ~clear;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid_q & out_ready & ena & ~clear;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (in_xfer) begin
            acc_d   = ACC_W'(product);
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = (N_SAMPLES == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            acc_d = sum;
            cnt_d = cnt_inc;
            if (carry) ovf_d = 1'b1;
            if (cnt_inc == N_LAST) state_d = DONE;
          end
        end
        DONE: begin
          // overflow stays visible until the next frame's first product.
          if (out_xfer) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign acc_out    = acc_q;
  assign sample_cnt = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_acumulador_productos.sv
// Self-checking bench: default, narrow (ACC_W=8, N=2) and single-sample instances.
// Frame results are queued when driven and compared when the output handshake fires.
module tb_acumulador_productos;

  logic        clk, rst_n, ena, clear, out_ready;
  logic [7:0]  product;
  logic        in_valid_a, in_valid_b, in_valid_c;
  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [10:0] acc_a, acc_c;
  logic [7:0]  acc_b;
  logic [7:0]  cnt_a, cnt_b, cnt_c;
  logic        ovf_a, ovf_b, ovf_c;

  int errors = 0;
  int checks = 0;

  typedef struct { int acc; int cnt; int ovf; } exp_t;
  typedef struct { int prod; int acc; int ovf; } vec_t;
  exp_t q_a[$], q_b[$], q_c[$];

`ifdef ACUM_SATURATE_EN
  localparam int EXP_B_OVF_ACC = 255;
`else
  localparam int EXP_B_OVF_ACC = 44;
`endif

  acumulador_productos u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .product(product),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .acc_out(acc_a), .sample_cnt(cnt_a), .overflow(ovf_a)
  );

  acumulador_productos #(.ACC_W(8), .N_SAMPLES(2), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .product(product),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .acc_out(acc_b), .sample_cnt(cnt_b), .overflow(ovf_b)
  );

  acumulador_productos #(.ACC_W(11), .N_SAMPLES(1), .CNT_W(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
    .in_valid(in_valid_c), .in_ready(in_ready_c), .product(product),
    .out_valid(out_valid_c), .out_ready(out_ready),
    .acc_out(acc_c), .sample_cnt(cnt_c), .overflow(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: an output transfer happens at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ena && !clear && out_ready) begin
      if (out_valid_a) begin
        if (q_a.size() == 0) chk("sb_a_empty", 0, 1);
        else begin
          e = q_a.pop_front();
          chk("sb_a_acc", acc_a, e.acc); chk("sb_a_cnt", cnt_a, e.cnt); chk("sb_a_ovf", ovf_a, e.ovf);
          $display("frame a: acc=%0d cnt=%0d ovf=%0d", acc_a, cnt_a, ovf_a);
        end
      end
      if (out_valid_b) begin
        if (q_b.size() == 0) chk("sb_b_empty", 0, 1);
        else begin
          e = q_b.pop_front();
          chk("sb_b_acc", acc_b, e.acc); chk("sb_b_cnt", cnt_b, e.cnt); chk("sb_b_ovf", ovf_b, e.ovf);
          $display("frame b: acc=%0d cnt=%0d ovf=%0d", acc_b, cnt_b, ovf_b);
        end
      end
      if (out_valid_c) begin
        if (q_c.size() == 0) chk("sb_c_empty", 0, 1);
        else begin
          e = q_c.pop_front();
          chk("sb_c_acc", acc_c, e.acc); chk("sb_c_cnt", cnt_c, e.cnt); chk("sb_c_ovf", ovf_c, e.ovf);
          $display("frame c: acc=%0d cnt=%0d ovf=%0d", acc_c, cnt_c, ovf_c);
        end
      end
    end
  end

  // Presents one product and returns just after the edge that accepts it.
  task automatic put(input int w, input int p);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    product = 8'(p);
    case (w)
      0:       in_valid_a = 1'b1;
      1:       in_valid_b = 1'b1;
      default: in_valid_c = 1'b1;
    endcase
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      rdy = (w == 0) ? in_ready_a : (w == 1) ? in_ready_b : in_ready_c;
      if (rdy) ok = 1'b1;
    end
    if (!ok) chk("put_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[4];
    int   last, rises;
    vecs[0] = '{prod: 225, acc: 1800, ovf: 0};
    vecs[1] = '{prod: 2,   acc: 16,   ovf: 0};
    vecs[2] = '{prod: 255, acc: 2040, ovf: 0};
    vecs[3] = '{prod: 0,   acc: 0,    ovf: 0};

    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; out_ready = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_valid_c = 1'b0; product = 8'd0;
    #12;
    chk("rst_in_ready", in_ready_a, 0); chk("rst_out_valid", out_valid_a, 0);
    chk("rst_acc", acc_a, 0); chk("rst_cnt", cnt_a, 0); chk("rst_ovf", ovf_a, 0);
    step(); rst_n = 1'b1; #1;
    chk("post_rst_in_ready", in_ready_a, 1);

    for (int i = 0; i < 4; i++) begin
      q_a.push_back('{acc: vecs[i].acc, cnt: 8, ovf: vecs[i].ovf});
      for (int j = 0; j < 7; j++) put(0, vecs[i].prod);
      chk("tbl_early_valid", out_valid_a, 0);
      put(0, vecs[i].prod);
      in_valid_a = 1'b0;
      chk("tbl_out_valid", out_valid_a, 1); chk("tbl_acc", acc_a, vecs[i].acc);
      chk("tbl_cnt", cnt_a, 8); chk("tbl_ovf", ovf_a, vecs[i].ovf);
      step();
      chk("tbl_idle_valid", out_valid_a, 0); chk("tbl_idle_acc", acc_a, 0);
      chk("tbl_idle_cnt", cnt_a, 0); chk("tbl_idle_ready", in_ready_a, 1);
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    q_a.push_back('{acc: 8, cnt: 8, ovf: 0});
    for (int j = 0; j < 8; j++) put(0, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid_a, 1); chk("bp_acc", acc_a, 8); chk("bp_in_ready", in_ready_a, 0);
    end
    step(); in_valid_a = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_release_valid", out_valid_a, 0); chk("bp_release_ready", in_ready_a, 1);

    // Clear mid-frame, with a product presented alongside.
    for (int j = 0; j < 3; j++) put(0, 10);
    in_valid_a = 1'b0;
    chk("clr_pre_acc", acc_a, 30); chk("clr_pre_cnt", cnt_a, 3);
    clear = 1'b1; in_valid_a = 1'b1; product = 8'd5;
    @(negedge clk); chk("clr_in_ready", in_ready_a, 0);
    step(); chk("clr_acc", acc_a, 0); chk("clr_cnt", cnt_a, 0);
    step(); clear = 1'b0; in_valid_a = 1'b0; #1;
    chk("clr_hold_cnt", cnt_a, 0); chk("clr_hold_acc", acc_a, 0);
    q_a.push_back('{acc: 16, cnt: 8, ovf: 0});
    for (int j = 0; j < 8; j++) put(0, 2);
    in_valid_a = 1'b0;
    chk("clr_next_acc", acc_a, 16);
    step();

    // Enable low freezes the frame, then an asynchronous reset aborts it.
    for (int j = 0; j < 3; j++) put(0, 3);
    ena = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ena_in_ready", in_ready_a, 0); chk("ena_cnt", cnt_a, 3);
    end
    step(); ena = 1'b1;
    put(0, 3); put(0, 3);
    in_valid_a = 1'b0;
    chk("ena_resume_cnt", cnt_a, 5); chk("ena_resume_acc", acc_a, 15);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc", acc_a, 0); chk("arst_cnt", cnt_a, 0); chk("arst_valid", out_valid_a, 0);
    chk("arst_ready", in_ready_a, 0); chk("arst_ovf", ovf_a, 0);
    step(); rst_n = 1'b1; #1;
    chk("arst_restart_cnt", cnt_a, 0);
    q_a.push_back('{acc: 32, cnt: 8, ovf: 0});
    for (int j = 0; j < 8; j++) put(0, 4);
    in_valid_a = 1'b0;
    chk("arst_frame_acc", acc_a, 32);
    step();

    // Narrow accumulator overflow.
    q_b.push_back('{acc: EXP_B_OVF_ACC, cnt: 2, ovf: 1});
    put(1, 200); put(1, 100);
    in_valid_b = 1'b0;
    chk("ovf_acc", acc_b, EXP_B_OVF_ACC); chk("ovf_flag", ovf_b, 1); chk("ovf_valid", out_valid_b, 1);
    step();
    chk("ovf_sticky_idle", ovf_b, 1); chk("ovf_idle_acc", acc_b, 0);
    q_b.push_back('{acc: 30, cnt: 2, ovf: 0});
    put(1, 10);
    chk("ovf_cleared_first", ovf_b, 0);
    put(1, 20);
    in_valid_b = 1'b0;
    step();

    // Single-sample frames.
    q_c.push_back('{acc: 77, cnt: 1, ovf: 0});
    put(2, 77);
    in_valid_c = 1'b0;
    chk("n1_valid", out_valid_c, 1); chk("n1_acc", acc_c, 77);
    step();
    chk("n1_idle_valid", out_valid_c, 0);

    // Full throughput: one result every N_SAMPLES+1 cycles.
    for (int f = 0; f < 3; f++) q_a.push_back('{acc: 40, cnt: 8, ovf: 0});
    product = 8'd5; in_valid_a = 1'b1;
    last = -1; rises = 0;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      if (out_valid_a) begin
        if (last >= 0) chk("thru_spacing", k - last, 9);
        last = k; rises++;
      end
    end
    step(); in_valid_a = 1'b0;
    chk("thru_results", rises, 3);
    step();

    chk("sb_a_drained", q_a.size(), 0);
    chk("sb_b_drained", q_b.size(), 0);
    chk("sb_c_drained", q_c.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
